// File: rtl/util_upack2_timestamp.sv
// Timestamp gate between a DMA stream and the DAC unpacker: each block opens with a 64-bit header word, and the block is held until the sample counter reaches that header.
// Optional build macro UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN: discard late blocks instead of playing them immediately.
module util_upack2_timestamp #(
  parameter int NUM_OF_CHANNELS     = 4,
  parameter int SAMPLE_DATA_WIDTH   = 16,
  parameter int SAMPLES_PER_CHANNEL = 1,
  localparam int DW = NUM_OF_CHANNELS * SAMPLE_DATA_WIDTH * SAMPLES_PER_CHANNEL
) (
  input  logic          dac_clk,
  input  logic          dac_resetn,
  input  logic [63:0]   timestamp,
  input  logic [31:0]   timestamp_every,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          late,
  output logic          underflow,
  output logic [15:0]   late_count
);

  generate
    if (DW != 64) begin : g_dw_check
      $error("util_upack2_timestamp: channel/sample configuration must give a 64-bit word");
    end
  endgenerate

  typedef enum logic [2:0] {S_PASS, S_HEADER, S_WAIT, S_STREAM, S_LATE} state_t;

  state_t      r_state;
  logic [63:0] r_ts_target;
  logic [31:0] r_blk_len;
  logic [31:0] r_cnt;
  logic [15:0] r_late_count;

  state_t w_state_next;
  logic   w_s_ready;
  logic   w_m_valid;
  logic   w_late;
  logic   w_underflow;
  logic   w_hdr_take;
  logic   w_word_take;
  logic   w_last;

  assign w_last = (r_cnt == r_blk_len - 32'd1);

  always_comb begin
    w_state_next = r_state;
    w_s_ready    = 1'b0;
    w_m_valid    = 1'b0;
    w_late       = 1'b0;
    w_underflow  = 1'b0;
    w_hdr_take   = 1'b0;
    w_word_take  = 1'b0;
    case (r_state)
      S_PASS: begin
        w_m_valid = s_valid;
        w_s_ready = m_ready;
        // Only leave pass-through between words so nothing in flight is cut.
        if (timestamp_every != 32'd0 && !(s_valid && m_ready))
          w_state_next = S_HEADER;
      end
      S_HEADER: begin
        w_s_ready = 1'b1;
        if (timestamp_every == 32'd0) begin
          w_state_next = S_PASS;
        end else if (s_valid) begin
          w_hdr_take = 1'b1;
          if (s_data <= timestamp) begin
            w_late       = 1'b1;
            w_state_next = S_LATE;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (timestamp >= r_ts_target)
          w_state_next = S_STREAM;
      end
      S_STREAM: begin
        w_m_valid   = s_valid;
        w_s_ready   = m_ready;
        w_underflow = m_ready && !s_valid;
        w_word_take = s_valid && m_ready;
        if (w_word_take && w_last)
          w_state_next = S_HEADER;
      end
      S_LATE: begin
`ifdef UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN
        w_s_ready   = 1'b1;
        w_word_take = s_valid;
`else
        w_m_valid   = s_valid;
        w_s_ready   = m_ready;
        w_underflow = m_ready && !s_valid;
        w_word_take = s_valid && m_ready;
`endif
        if (w_word_take && w_last)
          w_state_next = S_HEADER;
      end
      default: w_state_next = S_PASS;
    endcase
  end

  always_ff @(posedge dac_clk or negedge dac_resetn) begin
    if (!dac_resetn) begin
      r_state      <= S_PASS;
      r_ts_target  <= 64'd0;
      r_blk_len    <= 32'd0;
      r_cnt        <= 32'd0;
      r_late_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      // Block length is frozen at the header so mid-block changes wait for the next block.
      if (w_hdr_take) begin
        r_ts_target <= s_data;
        r_blk_len   <= timestamp_every;
        r_cnt       <= 32'd0;
      end else if (w_word_take) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_late && r_late_count != 16'hFFFF)
        r_late_count <= r_late_count + 16'd1;
    end
  end

  // Handshake outputs are forced low while reset is held, independent of the clock.
  assign s_ready    = dac_resetn & w_s_ready;
  assign m_valid    = dac_resetn & w_m_valid;
  assign late       = dac_resetn & w_late;
  assign underflow  = dac_resetn & w_underflow;
  assign m_data     = s_data;
  assign late_count = r_late_count;

endmodule

// File: doc/util_upack2_timestamp.md
UTIL_UPACK2_TIMESTAMP -- requirements
Module: util_upack2_timestamp

Interface
REQ-001 Parameter NUM_OF_CHANNELS, default 4, number of packed DAC channels.
REQ-002 Parameter SAMPLE_DATA_WIDTH, default 16, bits per sample.
REQ-003 Parameter SAMPLES_PER_CHANNEL, default 1, samples per channel per word; DW = product of the three SHALL equal 64, else elaboration error.
REQ-004 dac_clk  in  1  sole clock; all logic on rising edge.
REQ-005 dac_resetn  in  1  asynchronous active-low reset.
REQ-006 timestamp  in  64  free-running sample counter, +1 per dac_clk.
REQ-007 timestamp_every  in  32  data words per block; 0 = timestamping disabled.
REQ-008 s_valid / s_ready / s_data  in / out / DW  timestamped stream from DMA.
REQ-009 m_valid / m_ready / m_data  out / in / DW  untimestamped stream to unpacker.
REQ-010 late  out  1  one-cycle pulse, block header already in the past.
REQ-011 underflow  out  1  one-cycle pulse, sink ready mid-block with no source data.
REQ-012 late_count  out  16  saturating count of late blocks.

Function
REQ-013 States: PASS, HEADER, WAIT, STREAM, LATE.
REQ-014 PASS: m_valid=s_valid, m_data=s_data, s_ready=m_ready, zero latency; exit to HEADER on a cycle with timestamp_every!=0 and no handshake.
REQ-015 HEADER: s_ready=1, m_valid=0; if timestamp_every==0, go PASS; on handshake latch s_data as ts_target and timestamp_every as blk_len, clear word counter.
REQ-016 At header handshake, if ts_target <= timestamp (unsigned 64-bit): go LATE and pulse late; else go WAIT.
REQ-017 WAIT: s_ready=0, m_valid=0; go STREAM on the edge where timestamp >= ts_target; first data word presentable the cycle after timestamp == ts_target.
REQ-018 STREAM: m_valid=s_valid, m_data=s_data, s_ready=m_ready, zero latency; counter increments per handshake.
REQ-019 LATE: behaviour set by Configuration; word counter increments per accepted word identically.
REQ-020 On acceptance of word blk_len-1 (STREAM or LATE), go HEADER next cycle; back-to-back blocks allowed.
REQ-021 Changes to timestamp_every mid-block SHALL have no effect until next HEADER.
REQ-022 underflow pulses on each STREAM cycle with m_ready=1, s_valid=0; no pulse in PASS, WAIT, HEADER.
REQ-023 late_count increments on each late pulse, saturates at 0xFFFF, never wraps.
REQ-024 m_data SHALL be don't-care when m_valid=0; m_valid SHALL not depend on m_ready.

Reset
REQ-025 dac_resetn low: state PASS, ts_target=0, blk_len=0, counter=0, late=0, underflow=0, late_count=0, m_valid=0, s_ready=0, asynchronously.
REQ-026 Reset mid-block discards the partial block; first cycle after release behaves as PASS.

Configuration
REQ-027 Macro UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN defined: LATE sets s_ready=1, m_valid=0, discarding blk_len words.
REQ-028 Macro undefined: LATE behaves as STREAM (late block played immediately); late pulse and late_count unchanged.

Verification
REQ-029 timestamp_every=0, 12 words 0x0001..000C, m_ready=1 -> identical 12 words, same cycles, no late/underflow.
REQ-030 timestamp_every=4, timestamp=100 at header, header 0x200, words A,B,C,D -> m_valid first high cycle after timestamp==0x200, A..D in order, header never on m_data.
REQ-031 timestamp_every=4, header 0x10 at timestamp=0x50 -> late pulse, late_count=1; DROP_EN: no m_valid for 4 words; without: 4 words emitted immediately.
REQ-032 STREAM, m_ready=1, s_valid low 3 cycles -> 3 underflow pulses, words resume in order, block length still 4.
REQ-033 timestamp_every changed 4->8 after word 2 -> current block ends after 4 words; next block 8 words.
REQ-034 dac_resetn low during word 2 of block -> outputs to reset values; after release, PASS behaviour with timestamp_every=0.
